// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider (restoring shift-subtract).
// Produces quotient (truncated toward zero) and remainder (sign of dividend)
// WIDTH+1 edges after the start edge; divide-by-zero answers on the start edge.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } divState_e;

  divState_e        state;
  logic [CW-1:0]    iterCount;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] quotReg;
  logic [WIDTH-1:0] divMag;
  logic             signQ;
  logic             signR;
  logic             ovfPending;

  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             isOverflowPair;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trialDiff;
  logic             trialOk;
  logic [WIDTH-1:0] negQuot;
  logic [WIDTH-1:0] negRem;

  // Operand magnitudes and one restoring iteration step.
  // The partial remainder is always below |B| <= 2^(WIDTH-1), so it is kept
  // WIDTH bits wide; only the shifted trial value needs the extra bit.
  always_comb begin
    magA           = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    magB           = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    isOverflowPair = (data_operandA == MIN_NEG) && (&data_operandB);
    shifted        = {partRem, quotReg[WIDTH-1]};
    trialDiff      = {1'b0, shifted} - {2'b00, divMag};
    trialOk        = ~trialDiff[WIDTH+1];
    negQuot        = -quotReg;
    negRem         = -partRem;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      iterCount      <= '0;
      partRem        <= '0;
      quotReg        <= '0;
      divMag         <= '0;
      signQ          <= 1'b0;
      signR          <= 1'b0;
      ovfPending     <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_DIV) begin
            quotReg   <= magA;
            divMag    <= magB;
            signQ     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            signR     <= data_operandA[WIDTH-1];
            partRem   <= '0;
            iterCount <= '0;
            busy      <= 1'b1;
            if (data_operandB == '0) begin
              state          <= DONE;
              ovfPending     <= 1'b0;
              data_result    <= '0;
              data_remainder <= data_operandA;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else begin
              state      <= RUN;
              ovfPending <= isOverflowPair;
            end
          end
        end
        RUN: begin
          partRem   <= trialOk ? trialDiff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quotReg   <= {quotReg[WIDTH-2:0], trialOk};
          iterCount <= iterCount + 1'b1;
          if (iterCount == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          data_result    <= signQ ? negQuot : quotReg;
          data_remainder <= signR ? negRem : partRem;
          data_exception <= ovfPending;
          data_resultRDY <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=32) against an
// arithmetic reference model of signed truncating division.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset;
  logic         ctrlDiv;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         exception;
  logic         resultRdy;
  logic         busy;

  int nCompared;
  int nMismatched;

  seq_divider #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_DIV      (ctrlDiv),
    .data_operandA (opA),
    .data_operandB (opB),
    .data_result   (result),
    .data_remainder(remainder),
    .data_exception(exception),
    .data_resultRDY(resultRdy),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed division truncating toward zero, remainder takes the
  // dividend's sign; zero divisor and MIN/-1 flag an exception.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0;
      r = a;
      e = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      e = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
  endfunction

  function automatic int exp_edge(input logic [W-1:0] b);
    return (b == '0) ? 0 : int'(W) + 1;
  endfunction

  // Starts one division and waits (bounded) for resultRDY. rdyEdge is the
  // number of rising edges after the start edge at which resultRDY was set,
  // or -1 on timeout. pulseOk: the following cycle has resultRDY=0, busy=0.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [W-1:0] rem,
                        output logic exc, output int rdyEdge, output logic pulseOk);
    @(negedge clock);
    opA = a;
    opB = b;
    ctrlDiv = 1'b1;
    @(posedge clock);
    #1;
    ctrlDiv = 1'b0;
    opA = $urandom;
    opB = $urandom;
    rdyEdge = -1;
    res = 'x;
    rem = 'x;
    exc = 1'bx;
    pulseOk = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (resultRdy) begin
        rdyEdge = k;
        break;
      end
    end
    if (rdyEdge >= 0) begin
      res = result;
      rem = remainder;
      exc = exception;
      @(negedge clock);
      pulseOk = !resultRdy && !busy;
    end
  endtask

  task automatic test_reset;
    logic [W*2+2:0] outs;
    reset = 1'b1;
    ctrlDiv = 1'b0;
    opA = '0;
    opB = '0;
    repeat (3) @(negedge clock);
    outs = {result, remainder, exception, resultRdy, busy};
    nCompared++;
    if (outs !== '0) begin
      nMismatched++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    nCompared++;
    if (busy !== 1'b0 || resultRdy !== 1'b0) begin
      nMismatched++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b expected 0/0", busy, resultRdy);
    end
  endtask

  task automatic test_signs;
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    logic [W-1:0] tq[4];
    logic [W-1:0] tr[4];
    logic [W-1:0] res, rem;
    logic exc, pulseOk;
    int rdyEdge;
    ta = '{32'd100, -32'd100, 32'd100, -32'd100};
    tb = '{32'd7, 32'd7, -32'd7, -32'd7};
    tq = '{32'd14, 32'hFFFF_FFF2, -32'd14, 32'd14};
    tr = '{32'd2, -32'd2, 32'd2, -32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], res, rem, exc, rdyEdge, pulseOk);
      nCompared++;
      if (res !== tq[i] || rem !== tr[i] || exc !== 1'b0) begin
        nMismatched++;
        $display("FAIL signs[%0d]: got q=%h r=%h e=%b expected q=%h r=%h e=0",
                 i, res, rem, exc, tq[i], tr[i]);
      end
      nCompared++;
      if (rdyEdge !== int'(W) + 1 || pulseOk !== 1'b1) begin
        nMismatched++;
        $display("FAIL signs_timing[%0d]: got edge=%0d pulseOk=%b expected edge=%0d pulseOk=1",
                 i, rdyEdge, pulseOk, W + 1);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] res, rem;
    logic exc, pulseOk;
    int rdyEdge;
    run_op(32'd5, 32'd0, res, rem, exc, rdyEdge, pulseOk);
    nCompared++;
    if (res !== 32'd0 || rem !== 32'd5 || exc !== 1'b1) begin
      nMismatched++;
      $display("FAIL div_zero: got q=%h r=%h e=%b expected q=0 r=5 e=1", res, rem, exc);
    end
    nCompared++;
    if (rdyEdge !== 0 || pulseOk !== 1'b1) begin
      nMismatched++;
      $display("FAIL div_zero_timing: got edge=%0d pulseOk=%b expected edge=0 pulseOk=1",
               rdyEdge, pulseOk);
    end
  endtask

  task automatic test_overflow;
    logic [W-1:0] res, rem;
    logic exc, pulseOk;
    int rdyEdge;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, res, rem, exc, rdyEdge, pulseOk);
    nCompared++;
    if (res !== 32'h8000_0000 || rem !== 32'd0 || exc !== 1'b1 || rdyEdge !== int'(W) + 1) begin
      nMismatched++;
      $display("FAIL overflow: got q=%h r=%h e=%b edge=%0d expected q=80000000 r=0 e=1 edge=%0d",
               res, rem, exc, rdyEdge, W + 1);
    end
    // exception must clear on the next normal division
    run_op(32'd9, 32'd3, res, rem, exc, rdyEdge, pulseOk);
    nCompared++;
    if (res !== 32'd3 || rem !== 32'd0 || exc !== 1'b0) begin
      nMismatched++;
      $display("FAIL exc_clear: got q=%h r=%h e=%b expected q=3 r=0 e=0", res, rem, exc);
    end
  endtask

  task automatic test_boundaries;
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    logic [W-1:0] res, rem, eq, er;
    logic exc, ee, pulseOk;
    int rdyEdge;
    ta = '{32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000};
    tb = '{32'd5, 32'd1, 32'h8000_0000, 32'd100, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], res, rem, exc, rdyEdge, pulseOk);
      ref_div(ta[i], tb[i], eq, er, ee);
      nCompared++;
      if (res !== eq || rem !== er || exc !== ee || rdyEdge !== exp_edge(tb[i])) begin
        nMismatched++;
        $display("FAIL boundary[%0d] %h/%h: got q=%h r=%h e=%b edge=%0d expected q=%h r=%h e=%b edge=%0d",
                 i, ta[i], tb[i], res, rem, exc, rdyEdge, eq, er, ee, exp_edge(tb[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] eq, er;
    logic ee, seen;
    int gap;
    @(negedge clock);
    opA = 32'd100;
    opB = 32'd7;
    ctrlDiv = 1'b1;
    @(posedge clock);
    #1;
    ctrlDiv = 1'b0;
    repeat (9) @(negedge clock);
    opA = 32'd9;
    opB = 32'd3;
    ctrlDiv = 1'b1;
    @(negedge clock);
    ctrlDiv = 1'b0;
    @(negedge clock);
    opA = -32'd1000;
    opB = 32'd33;
    ctrlDiv = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (resultRdy) begin
        seen = 1'b1;
        break;
      end
    end
    nCompared++;
    if (seen !== 1'b1 || result !== 32'd14 || remainder !== 32'd2) begin
      nMismatched++;
      $display("FAIL busy_ignore: got seen=%b q=%h r=%h expected seen=1 q=e r=2",
               seen, result, remainder);
    end
    gap = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (resultRdy) begin
        gap = k;
        break;
      end
    end
    ctrlDiv = 1'b0;
    ref_div(-32'd1000, 32'd33, eq, er, ee);
    nCompared++;
    if (gap !== int'(W) + 3) begin
      nMismatched++;
      $display("FAIL b2b_gap: got %0d cycles expected %0d", gap, W + 3);
    end
    nCompared++;
    if (result !== eq || remainder !== er || exception !== ee) begin
      nMismatched++;
      $display("FAIL b2b_result: got q=%h r=%h e=%b expected q=%h r=%h e=%b",
               result, remainder, exception, eq, er, ee);
    end
    repeat (2) @(negedge clock);
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatched++;
      $display("FAIL b2b_no_third: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [W*2+2:0] outs;
    logic [W-1:0] res, rem;
    logic exc, pulseOk, sawRdy;
    int rdyEdge;
    @(negedge clock);
    opA = 32'd12345;
    opB = 32'd67;
    ctrlDiv = 1'b1;
    @(posedge clock);
    #1;
    ctrlDiv = 1'b0;
    repeat (15) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    outs = {result, remainder, exception, resultRdy, busy};
    nCompared++;
    if (outs !== '0) begin
      nMismatched++;
      $display("FAIL reset_mid_outputs: got %h expected 0", outs);
    end
    @(negedge clock);
    reset = 1'b0;
    sawRdy = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clock);
      if (resultRdy !== 1'b0 || busy !== 1'b0) sawRdy = 1'b1;
    end
    nCompared++;
    if (sawRdy !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_mid_discard: got activity=%b expected 0", sawRdy);
    end
    run_op(32'd81, 32'd9, res, rem, exc, rdyEdge, pulseOk);
    nCompared++;
    if (res !== 32'd9 || rem !== 32'd0 || exc !== 1'b0 || rdyEdge !== int'(W) + 1) begin
      nMismatched++;
      $display("FAIL reset_mid_restart: got q=%h r=%h e=%b edge=%0d expected q=9 r=0 e=0 edge=%0d",
               res, rem, exc, rdyEdge, W + 1);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, res, rem, eq, er;
    logic exc, ee, pulseOk;
    int rdyEdge;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(0, 40)) - 32'd20;
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = -($urandom >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 7) == 0) a = a >>> $urandom_range(16, 31);
      run_op(a, b, res, rem, exc, rdyEdge, pulseOk);
      ref_div(a, b, eq, er, ee);
      nCompared++;
      if (res !== eq || rem !== er || exc !== ee || rdyEdge !== exp_edge(b) || pulseOk !== 1'b1) begin
        nMismatched++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h e=%b edge=%0d p=%b expected q=%h r=%h e=%b edge=%0d p=1",
                 i, a, b, res, rem, exc, rdyEdge, pulseOk, eq, er, ee, exp_edge(b));
      end
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_signs();
    test_div_zero();
    test_overflow();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
